pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined MIPS core. It holds the fetch PC, advances it sequentially, and applies redirects from branch/jump resolution, exception entry and ERET. It captures the EPC and buffers a redirect that arrives while fetch is stalled, so that no redirect is lost. It supersedes the single-register PC, which had no redirect buffering and no exception path.

## Interface
- `PC_W`, 32: PC width in bits.
- `RESET_VEC`, 32'h0040_0000: PC value after reset.
- `EXC_VEC`, 32'h0040_0004: exception handler entry address.
- `INC`, 4: sequential increment.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: fetch enable; low holds all state except redirect capture.
- `stall` in 1: pipeline stall; high holds the PC.
- `br_valid` in 1: branch/jump redirect request.
- `br_target` in PC_W: branch/jump target.
- `eret_valid` in 1: return-from-exception request; target is the current EPC.
- `exc_valid` in 1: exception request; target is EXC_VEC.
- `exc_pc` in PC_W: PC of the faulting instruction, sampled with exc_valid.
- `pc_out` out PC_W: current fetch PC.
- `pc_valid` out 1: pc_out is a valid fetch address.
- `epc_out` out PC_W: exception PC register.
- `redir_pending` out 1: a buffered redirect is waiting.

## Operation
- The block advances when `ena && !stall`.
- Event priority is exc > eret > br. Only the winner is taken and the rest are dropped.
- On an exc winner, `epc <= exc_pc` at that edge, whether or not the block advances.
- Two-state FSM:
  - RUN: no pending redirect.
  - PEND: `pend_tgt` and `pend_pri` are held.
- RUN, advancing:
  - Event present: `pc_out <=` winner target.
  - No event: `pc_out <= pc_out + INC`, truncated to PC_W bits; wraps from all-ones to INC-1.
- RUN, not advancing, event present: store the target and priority, go to PEND.
- PEND, not advancing, new event:
  - Replaces the pending entry if its priority is ≥ the pending priority.
  - Otherwise the new event is dropped.
- PEND, advancing:
  - `pc_out <=` higher-priority of {new event, pending}; a tie goes to the new event.
  - Go to RUN.
- ERET target is the EPC value at the edge where the ERET is taken into the pending entry or applied.
- `pc_valid` is registered: 0 in reset, then equals `ena` sampled at each edge.
- `ena=0` never drives Z.
- `redir_pending = (state == PEND)`.

## Timing
- Reset values (async assert, synchronous-safe release):
  - `pc_out = RESET_VEC`, `epc_out = 0`, `pc_valid = 0`.
  - `state = RUN`, `redir_pending = 0`, `pend_*` cleared.
- Redirect latency when advancing: 1 cycle. A target presented in cycle N appears on `pc_out` after edge N.
- Buffered redirect: appears after the first advancing edge; `redir_pending` drops at that same edge.
- Event inputs are single-cycle and must not be held by the source.
- Reset mid-PEND discards the pending redirect.
- Reset never preserves EPC.
- exc, eret and br in the same cycle: only exc takes effect, and EPC updates.
- Misaligned `br_target` is applied unchanged; alignment checking belongs to the fetch stage.

## Structure
- Shared package `pc_pkg`:
  - FSM state enum {RUN, PEND}.
  - 2-bit priority codes PRI_NONE=0, PRI_BR=1, PRI_ERET=2, PRI_EXC=3.
  - Default RESET_VEC and EXC_VEC constants.
- Sub-module `pc_redirect_arb`: combinational picker.
  - Inputs: three requests, pending entry, and EPC.
  - Outputs: winner target, winner priority, and the take-new flag.
- `pc_gen` holds the FSM, the PC/EPC/pending registers, and `pc_valid`.

## Test plan
- Reset release, `ena=1`, `stall=0`, no events, 3 cycles: `pc_out` 0x00400000 → 0x00400004 → 0x00400008 → 0x0040000C; `pc_valid` is 1 from the first edge.
- `br_valid=1`, `br_target=0x00400100`, not stalled: `pc_out=0x00400100` next cycle, then 0x00400104.
- `stall=1` and `br_valid` to 0x00400200, then `exc_valid` with `exc_pc=0x00400050` two cycles later, then stall released:
  - `redir_pending` is 1 from the first edge.
  - `epc_out=0x00400050`.
  - On release `pc_out=0x00400004`.
- exc, eret and br asserted together, not stalled: `pc_out=EXC_VEC` and EPC = `exc_pc`; a later ERET gives `pc_out=exc_pc`.
- `PC_W=8`, `RESET_VEC=8'hFC`, free-run: `pc_out` 0xFC → 0x00 (wrap).
- Pending br, then `rst_n` pulsed low mid-PEND: `pc_out=RESET_VEC`, `redir_pending=0`; the branch target never appears.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
package pc_pkg;

   // Redirect FSM: RUN has no buffered redirect, PEND holds one.
   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pc_state_e;

   // Redirect priority codes; a larger value wins.
   typedef logic [1:0] pri_t;
   localparam pri_t PRI_NONE = 2'd0;
   localparam pri_t PRI_BR   = 2'd1;
   localparam pri_t PRI_ERET = 2'd2;
   localparam pri_t PRI_EXC  = 2'd3;

   // Default vectors for a 32-bit PC.
   localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0040_0004;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect picker: chooses the strongest new request
// (exc > eret > br) and weighs it against a buffered redirect.
module pc_redirect_arb
   import pc_pkg::*;
#(
   parameter int              PC_W    = 32,
   parameter logic [PC_W-1:0] EXC_VEC = PC_W'(EXC_VEC_DEF)
) (
   input  logic            exc_valid_i,
   input  logic            eret_valid_i,
   input  logic            br_valid_i,
   input  logic [PC_W-1:0] br_target_i,
   input  logic [PC_W-1:0] epc_i,
   input  logic            pend_valid_i,
   input  logic [PC_W-1:0] pend_tgt_i,
   input  pri_t            pend_pri_i,
   output logic [PC_W-1:0] win_tgt_o,
   output pri_t            win_pri_o,
   output logic            take_new_o
);

   logic [PC_W-1:0] new_tgt;
   pri_t            new_pri;

   // Pick the new-request winner, then decide new vs. buffered (tie -> new).
   always_comb begin
      new_tgt = '0;
      new_pri = PRI_NONE;
      if (exc_valid_i) begin
         new_tgt = EXC_VEC;
         new_pri = PRI_EXC;
      end else if (eret_valid_i) begin
         new_tgt = epc_i;
         new_pri = PRI_ERET;
      end else if (br_valid_i) begin
         new_tgt = br_target_i;
         new_pri = PRI_BR;
      end

      take_new_o = (new_pri != PRI_NONE) &&
                   (!pend_valid_i || (new_pri >= pend_pri_i));

      win_tgt_o = '0;
      win_pri_o = PRI_NONE;
      if (take_new_o) begin
         win_tgt_o = new_tgt;
         win_pri_o = new_pri;
      end else if (pend_valid_i) begin
         win_tgt_o = pend_tgt_i;
         win_pri_o = pend_pri_i;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, branch/exception/ERET
// redirects, EPC capture, and a one-entry buffer for redirects seen while
// fetch is not advancing.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
   parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
   parameter int              INC       = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            stall,
   input  logic            br_valid,
   input  logic [PC_W-1:0] br_target,
   input  logic            eret_valid,
   input  logic            exc_valid,
   input  logic [PC_W-1:0] exc_pc,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic [PC_W-1:0] epc_out,
   output logic            redir_pending
);

   pc_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
   pri_t            pend_pri_q, pend_pri_d;
   logic            pc_valid_q;

   logic [PC_W-1:0] win_tgt;
   pri_t            win_pri;
   logic            take_new;
   logic            adv;

   assign adv = ena && !stall;

   pc_redirect_arb #(
      .PC_W    (PC_W),
      .EXC_VEC (EXC_VEC)
   ) u_arb (
      .exc_valid_i  (exc_valid),
      .eret_valid_i (eret_valid),
      .br_valid_i   (br_valid),
      .br_target_i  (br_target),
      .epc_i        (epc_q),
      .pend_valid_i (state_q == PEND),
      .pend_tgt_i   (pend_tgt_q),
      .pend_pri_i   (pend_pri_q),
      .win_tgt_o    (win_tgt),
      .win_pri_o    (win_pri),
      .take_new_o   (take_new)
   );

   // Next-state: advance or redirect the PC, or buffer the redirect while held.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      pend_tgt_d = pend_tgt_q;
      pend_pri_d = pend_pri_q;

      // Exception always wins among new events, so EPC follows exc_valid.
      if (exc_valid) begin
         epc_d = exc_pc;
      end

      if (adv) begin
         if (win_pri != PRI_NONE) begin
            pc_d = win_tgt;
         end else begin
            pc_d = pc_q + PC_W'(INC);
         end
         state_d    = RUN;
         pend_tgt_d = '0;
         pend_pri_d = PRI_NONE;
      end else if (take_new) begin
         pend_tgt_d = win_tgt;
         pend_pri_d = win_pri;
         state_d    = PEND;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= RESET_VEC;
         epc_q      <= '0;
         pend_tgt_q <= '0;
         pend_pri_q <= PRI_NONE;
         pc_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_pri_q <= pend_pri_d;
         pc_valid_q <= ena;
      end
   end

   assign pc_out        = pc_q;
   assign pc_valid      = pc_valid_q;
   assign epc_out       = epc_q;
   assign redir_pending = (state_q == PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance plus an 8-bit instance for
// the wrap-around case, both driven from the same stimulus.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n, ena, stall, br_valid, eret_valid, exc_valid;
   logic [31:0] br_target, exc_pc;
   logic [31:0] pc_out, epc_out;
   logic        pc_valid, redir_pending;

   logic [7:0]  br_target8, exc_pc8, pc_out8, epc_out8;
   logic        pc_valid8, redir_pending8;

   int n_cmp = 0;
   int n_err = 0;

   assign br_target8 = br_target[7:0];
   assign exc_pc8    = exc_pc[7:0];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .stall         (stall),
      .br_valid      (br_valid),
      .br_target     (br_target),
      .eret_valid    (eret_valid),
      .exc_valid     (exc_valid),
      .exc_pc        (exc_pc),
      .pc_out        (pc_out),
      .pc_valid      (pc_valid),
      .epc_out       (epc_out),
      .redir_pending (redir_pending)
   );

   pc_gen #(
      .PC_W      (8),
      .RESET_VEC (8'hFC),
      .EXC_VEC   (8'h04),
      .INC       (4)
   ) dut8 (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .stall         (stall),
      .br_valid      (br_valid),
      .br_target     (br_target8),
      .eret_valid    (eret_valid),
      .exc_valid     (exc_valid),
      .exc_pc        (exc_pc8),
      .pc_out        (pc_out8),
      .pc_valid      (pc_valid8),
      .epc_out       (epc_out8),
      .redir_pending (redir_pending8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      br_valid   = 1'b0;
      eret_valid = 1'b0;
      exc_valid  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; stall = 1'b0;
      br_target = '0; exc_pc = '0;
      clear_events();

      // Reset state
      step(); step();
      check("rst_pc",      pc_out, 32'h0040_0000);
      check("rst_epc",     epc_out, 32'h0);
      check("rst_valid",   {31'b0, pc_valid}, 32'h0);
      check("rst_pending", {31'b0, redir_pending}, 32'h0);
      check("rst_pc8",     {24'b0, pc_out8}, 32'h0000_00FC);

      // Free run from reset
      rst_n = 1'b1; ena = 1'b1;
      step();
      check("run1_pc",    pc_out, 32'h0040_0004);
      check("run1_valid", {31'b0, pc_valid}, 32'h1);
      check("wrap_pc8",   {24'b0, pc_out8}, 32'h0000_0000);
      step();
      check("run2_pc",    pc_out, 32'h0040_0008);
      check("run2_pc8",   {24'b0, pc_out8}, 32'h0000_0004);
      step();
      check("run3_pc",    pc_out, 32'h0040_000C);

      // Unstalled branch
      br_valid = 1'b1; br_target = 32'h0040_0100;
      step(); clear_events();
      check("br_pc",      pc_out, 32'h0040_0100);
      step();
      check("br_next_pc", pc_out, 32'h0040_0104);

      // Stalled branch, later exception overrides, then release
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h0040_0200;
      step(); clear_events();
      check("stall_pend",   {31'b0, redir_pending}, 32'h1);
      check("stall_pc",     pc_out, 32'h0040_0104);
      step();
      check("stall_pend2",  {31'b0, redir_pending}, 32'h1);
      exc_valid = 1'b1; exc_pc = 32'h0040_0050;
      step(); clear_events();
      check("stall_epc",    epc_out, 32'h0040_0050);
      check("stall_pc2",    pc_out, 32'h0040_0104);
      stall = 1'b0;
      step();
      check("release_pc",   pc_out, 32'h0040_0004);
      check("release_pend", {31'b0, redir_pending}, 32'h0);
      step();
      check("release_next", pc_out, 32'h0040_0008);

      // exc, eret and br together: exception only
      exc_valid = 1'b1; eret_valid = 1'b1; br_valid = 1'b1;
      exc_pc = 32'h0040_0080; br_target = 32'h0040_0300;
      step(); clear_events();
      check("triple_pc",  pc_out, 32'h0040_0004);
      check("triple_epc", epc_out, 32'h0040_0080);
      eret_valid = 1'b1;
      step(); clear_events();
      check("eret_pc",    pc_out, 32'h0040_0080);
      check("eret_epc",   epc_out, 32'h0040_0080);

      // Pending exception is not displaced by a later branch
      stall = 1'b1; exc_valid = 1'b1; exc_pc = 32'h0040_0090;
      step(); clear_events();
      br_valid = 1'b1; br_target = 32'h0040_0400;
      step(); clear_events();
      check("drop_pend", {31'b0, redir_pending}, 32'h1);
      stall = 1'b0;
      step();
      check("drop_pc",   pc_out, 32'h0040_0004);
      check("drop_epc",  epc_out, 32'h0040_0090);

      // Fetch disabled: PC held, pc_valid low
      ena = 1'b0;
      step();
      check("dis_valid", {31'b0, pc_valid}, 32'h0);
      check("dis_pc",    pc_out, 32'h0040_0004);
      ena = 1'b1;
      step();
      check("en_valid",  {31'b0, pc_valid}, 32'h1);
      check("en_pc",     pc_out, 32'h0040_0008);

      // Reset while a branch is pending
      stall = 1'b1; br_valid = 1'b1; br_target = 32'h0040_0500;
      step(); clear_events();
      check("rpend_pend", {31'b0, redir_pending}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("rpend_pc",      pc_out, 32'h0040_0000);
      check("rpend_clear",   {31'b0, redir_pending}, 32'h0);
      check("rpend_epc",     epc_out, 32'h0);
      #2;
      rst_n = 1'b1; stall = 1'b0;
      step();
      check("rpend_after",  pc_out, 32'h0040_0004);
      step();
      check("rpend_after2", pc_out, 32'h0040_0008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
